// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execute-stage ALU: operation codes and default width.
// Optional CLZ/CLO operations are enabled with the ALU_CLZ_EN macro.
package mips_alu_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Operation select codes driven by the decode stage.
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDU = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_SUBU = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_SLL  = 4'hA;
    localparam logic [3:0] ALU_SRL  = 4'hB;
    localparam logic [3:0] ALU_SRA  = 4'hC;
    localparam logic [3:0] ALU_LUI  = 4'hD;
    localparam logic [3:0] ALU_CLZ  = 4'hE;
    localparam logic [3:0] ALU_CLO  = 4'hF;

    // LUI places the 16-bit immediate in the upper half of the word.
    localparam int LUI_SHIFT = 16;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) ||
               (code == ALU_SRA) || (code == ALU_LUI);
    endfunction

endpackage

// File: rtl/mips_alu_shifter.sv
// Combinational shift unit for SLL/SRL/SRA/LUI; value is operand B, amount comes from A.
// Produces zero for any non-shift code so the parent mux can select it unconditionally.
import mips_alu_pkg::*;

module mips_alu_shifter #(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic [3:0]         control,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  value,
    output logic [DATA_W-1:0]  result
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        result = '0;
        case (control)
            ALU_SLL: result = value << shamt;
            ALU_SRL: result = value >> shamt;
            ALU_SRA: result = DATA_W'($signed(value) >>> shamt);
            ALU_LUI: result = value << LUI_SHIFT;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mips_alu.sv
// Registered 32-bit MIPS ALU: result, signed overflow and zero captured together each clock.
// Define ALU_CLZ_EN to turn reserved codes 0xE/0xF into CLZ/CLO.
import mips_alu_pkg::*;

module mips_alu #(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        control,
    input  logic [DATA_W-1:0] oper1,
    input  logic [DATA_W-1:0] oper2,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              zero
);

    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int MSB     = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic              lt_signed;
    logic              lt_unsigned;
    logic [DATA_W-1:0] shift_result;
    logic [DATA_W-1:0] next_result;
    logic              next_overflow;
    logic              next_zero;

    // Adder/subtractor; both run every cycle and the mux picks one.
    assign sum  = oper1 + oper2;
    assign diff = oper1 - oper2;

    // Signed overflow: like-signed operands for ADD (unlike for SUB) producing a sign flip from A.
    assign add_ovf = (oper1[MSB] == oper2[MSB]) && (sum[MSB]  != oper1[MSB]);
    assign sub_ovf = (oper1[MSB] != oper2[MSB]) && (diff[MSB] != oper1[MSB]);

    assign lt_signed   = $signed(oper1) < $signed(oper2);
    assign lt_unsigned = oper1 < oper2;

    mips_alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .control (control),
        .shamt   (oper1[SHAMT_W-1:0]),
        .value   (oper2),
        .result  (shift_result)
    );

`ifdef ALU_CLZ_EN
    localparam int CNT_W = $clog2(DATA_W) + 1;

    function automatic logic [CNT_W-1:0] lead_zeros(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] n;
        logic             done;
        n    = '0;
        done = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 1'b1;
            end
        end
        return n;
    endfunction

    logic [CNT_W-1:0] clz_count;
    logic [CNT_W-1:0] clo_count;

    // Leading ones of A are the leading zeros of its complement.
    assign clz_count = lead_zeros(oper1);
    assign clo_count = lead_zeros(~oper1);
`endif

    always_comb begin
        next_result   = '0;
        next_overflow = 1'b0;
        case (control)
            ALU_ADD: begin
                next_result   = sum;
                next_overflow = add_ovf;
            end
            ALU_ADDU: next_result = sum;
            ALU_SUB: begin
                next_result   = diff;
                next_overflow = sub_ovf;
            end
            ALU_SUBU: next_result = diff;
            ALU_AND:  next_result = oper1 & oper2;
            ALU_OR:   next_result = oper1 | oper2;
            ALU_XOR:  next_result = oper1 ^ oper2;
            ALU_NOR:  next_result = ~(oper1 | oper2);
            ALU_SLT:  next_result = {{(DATA_W-1){1'b0}}, lt_signed};
            ALU_SLTU: next_result = {{(DATA_W-1){1'b0}}, lt_unsigned};
`ifdef ALU_CLZ_EN
            ALU_CLZ:  next_result = {{(DATA_W-CNT_W){1'b0}}, clz_count};
            ALU_CLO:  next_result = {{(DATA_W-CNT_W){1'b0}}, clo_count};
`endif
            default: begin
                if (is_shift_op(control)) begin
                    next_result = shift_result;
                end
            end
        endcase
    end

    // zero derives from the value being registered, so it can never disagree with result.
    assign next_zero = (next_result == '0);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: only the output registers need a reset value; non-blocking assignments keep all three updating as one.
        if (rst) begin
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            result   <= next_result;
            overflow <= next_overflow;
            zero     <= next_zero;
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: expected outputs are queued at drive time and popped one cycle later.
// Build with +define+ALU_CLZ_EN to check the CLZ/CLO expectations instead of the reserved-code ones.
`timescale 1ns/1ps

module tb_mips_alu;
    import mips_alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         ovf;
        logic         zro;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [3:0]   control;
    logic [W-1:0] oper1;
    logic [W-1:0] oper2;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;

    exp_t sb[$];
    int   checks;
    int   errors;

    mips_alu #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .control  (control),
        .oper1    (oper1),
        .oper2    (oper2),
        .result   (result),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Pops the oldest expectation and compares it with the registered outputs.
    task automatic compare_head();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: no expected entry at t=%0t", $time);
            return;
        end
        e = sb.pop_front();
        if (result !== e.res) begin
            errors++;
            $display("FAIL %s.result: got %h expected %h", e.name, result, e.res);
        end
        checks++;
        if (overflow !== e.ovf) begin
            errors++;
            $display("FAIL %s.overflow: got %b expected %b", e.name, overflow, e.ovf);
        end
        checks++;
        if (zero !== e.zro) begin
            errors++;
            $display("FAIL %s.zero: got %b expected %b", e.name, zero, e.zro);
        end
    endtask

    // One op per cycle: drive at negedge, check the previous op's registered output first.
    task automatic step(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic eo, input string nm);
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) compare_head();
        control = c;
        oper1   = a;
        oper2   = b;
        e.name  = nm;
        e.res   = er;
        e.ovf   = eo;
        e.zro   = (er == '0);
        sb.push_back(e);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            @(negedge clk);
            compare_head();
        end
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (result !== '0 || overflow !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL %s: got result=%h overflow=%b zero=%b expected result=0 overflow=0 zero=1",
                     nm, result, overflow, zero);
        end
    endtask

    task automatic test_reset();
        #1;
        check_idle("reset_initial");
        @(negedge clk);
        rst = 1'b0;
        step(ALU_ADD, 32'd7, 32'd3, 32'h0000000A, 1'b0, "pre_reset_add");
        drain();
        #2;
        rst = 1'b1;
        #1;
        check_idle("reset_async");
        @(posedge clk);
        #1;
        check_idle("reset_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        step(ALU_ADD, 32'd1, 32'd1, 32'd2,  1'b0, "add_1_1");
        step(ALU_ADD, 32'd7, 32'd3, 32'd10, 1'b0, "add_7_3");
        step(ALU_ADD, 32'd2, 32'd3, 32'd5,  1'b0, "add_2_3");
        step(ALU_ADD, 32'd3, 32'd3, 32'd6,  1'b0, "add_3_3");
        drain();
        // New inputs must not reach the outputs before the next rising edge.
        control = ALU_ADD;
        oper1   = 32'd100;
        oper2   = 32'd200;
        #4;
        checks++;
        if (result !== 32'd6) begin
            errors++;
            $display("FAIL add_hold: got %h expected %h", result, 32'd6);
        end
    endtask

    task automatic test_arith_overflow();
        step(ALU_SUB,  32'd3,        32'd3,        32'h00000000, 1'b0, "sub_zero");
        step(ALU_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1, "add_ovf");
        step(ALU_ADDU, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, "addu_no_ovf");
        step(ALU_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, "sub_ovf");
        step(ALU_SUBU, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, "subu_no_ovf");
        step(ALU_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, "add_neg_ovf");
        step(ALU_SUB,  32'd5,        32'hFFFFFFFF, 32'd6,        1'b0, "sub_no_ovf");
        step(ALU_AND,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "and_clears_ovf");
        drain();
    endtask

    task automatic test_compare();
        step(ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, "slt_neg");
        step(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, "sltu_big");
        step(ALU_SLT,  32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, "slt_pos");
        step(ALU_SLTU, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, "sltu_small");
        drain();
    endtask

    task automatic test_shift();
        step(ALU_SLL, 32'd4,        32'h00000001, 32'h00000010, 1'b0, "sll_4");
        step(ALU_SRL, 32'd4,        32'h80000000, 32'h08000000, 1'b0, "srl_4");
        step(ALU_SRA, 32'd4,        32'h80000000, 32'hF8000000, 1'b0, "sra_4");
        step(ALU_LUI, 32'hDEAD,     32'h00001234, 32'h12340000, 1'b0, "lui");
        step(ALU_SLL, 32'hFFFFFFE0, 32'h12345678, 32'h12345678, 1'b0, "sll_0_high_bits");
        step(ALU_SRA, 32'h00000024, 32'h80000000, 32'hF8000000, 1'b0, "sra_ignores_high");
        step(ALU_SRL, 32'd31,       32'hFFFFFFFF, 32'h00000001, 1'b0, "srl_31");
        drain();
    endtask

    task automatic test_logic_reserved();
        step(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, "and");
        step(ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, "or");
        step(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, "xor");
        step(ALU_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, "nor");
`ifdef ALU_CLZ_EN
        step(4'hE, 32'h00010000, 32'h0, 32'd15, 1'b0, "clz");
        step(4'hE, 32'h00000000, 32'h0, 32'd32, 1'b0, "clz_zero");
        step(4'hF, 32'hFFFF0000, 32'h0, 32'd16, 1'b0, "clo");
        step(4'hF, 32'hFFFFFFFF, 32'h0, 32'd32, 1'b0, "clo_all");
`else
        step(4'hE, 32'h00010000, 32'h0, 32'd0, 1'b0, "reserved_e");
        step(4'hF, 32'hFFFF0000, 32'h1, 32'd0, 1'b0, "reserved_f");
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            if (i[0]) step(ALU_ADDU, a, b, a + b, 1'b0, "rand_addu");
            else      step(ALU_XOR,  a, b, a ^ b, 1'b0, "rand_xor");
        end
        drain();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        control = ALU_ADD;
        oper1   = '0;
        oper2   = '0;
        test_reset();
        test_add();
        test_arith_overflow();
        test_compare();
        test_shift();
        test_logic_reserved();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
